// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - tx_state_e        : serializer FSM states
//   - *_ADDR_DEFAULT    : default byte-write and status/control addresses
//   - STAT_*_BIT        : bit positions inside the status word
// ----------------------------------------------------------------------------
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [15:0] TX_ADDR_DEFAULT   = 16'hFFF0;
    localparam logic [15:0] STAT_ADDR_DEFAULT = 16'hFFF2;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT = 1;
    localparam int unsigned STAT_OVF_BIT  = 2;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH x WIDTH, first-word-fall-through read port.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   push_i, data_i    : write strobe and data; ignored when full without a pop
//   pop_i             : read strobe; ignored when empty
//   data_o            : head entry (valid while empty_o is low)
//   full_o, empty_o   : occupancy flags
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DEPTH = 4,   // power of 2, >= 2
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately left out of reset; the empty flag guards
    // every read, so clearing the pointers and count is enough.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap modulo DEPTH by natural overflow of PTR_W bits.
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-low reset
//   memwrite   : CPU store strobe
//   dataadr    : CPU data address
//   writedata  : CPU store data (byte in [7:0] at TX_ADDR, clear bit [0] at STAT_ADDR)
//   readdata   : combinational status {13'b0, overflow, full, busy} at STAT_ADDR
//   tx         : registered serial line, idle high
//   overflow   : registered sticky flag, set when a byte write is dropped
// ----------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [15:0] TX_ADDR      = TX_ADDR_DEFAULT,
    parameter logic [15:0] STAT_ADDR    = STAT_ADDR_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 4,   // >= 2
    parameter int unsigned DEPTH        = 4    // power of 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [15:0] dataadr,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        tx,
    output logic        overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;

    logic       push_req, clear_req, push_drop, pop;
    logic       fifo_full, fifo_empty, busy, baud_done;
    logic [7:0] fifo_head;
    logic       unused_wdata_hi;

    assign push_req        = memwrite && (dataadr == TX_ADDR);
    assign clear_req       = memwrite && (dataadr == STAT_ADDR) && writedata[0];
    assign push_drop       = push_req && fifo_full && !pop;
    assign unused_wdata_hi = ^writedata[15:8];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .data_i  (writedata[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    // Serializer next state. tx is registered, so each transition loads the
    // level of the bit that starts on the following cycle.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // Bit on the line stays in shift_q[0]; the next one is [1].
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (clear_req) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (dataadr == STAT_ADDR) begin
            readdata[STAT_BUSY_BIT] = busy;
            readdata[STAT_FULL_BIT] = fifo_full;
            readdata[STAT_OVF_BIT]  = overflow_q;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter TX_ADDR, default 16'hFFF0, data-byte write address.
REQ-002 Parameter STAT_ADDR, default 16'hFFF2, status/control address.
REQ-003 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (>=2).
REQ-004 Parameter DEPTH, default 4, FIFO entries (power of 2).
REQ-005 Port clk  input  1  system clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-low reset.
REQ-007 Port memwrite  input  1  CPU store strobe, one cycle per store.
REQ-008 Port dataadr  input  16  CPU data address (ALU result).
REQ-009 Port writedata  input  16  CPU store data.
REQ-010 Port readdata  output  16  status word, combinational.
REQ-011 Port tx  output  1  serial line, idle high, registered.
REQ-012 Port overflow  output  1  sticky dropped-write flag, registered.

Function
REQ-013 Push: memwrite=1 and dataadr==TX_ADDR pushes writedata[7:0] into the FIFO at that edge; writedata[15:8] ignored.
REQ-014 Push accepted when FIFO not full, or full with a pop on the same edge; otherwise dropped and overflow set to 1.
REQ-015 memwrite=1, dataadr==STAT_ADDR, writedata[0]=1 clears overflow; a same-edge set takes priority over clear.
REQ-016 Writes to any other address have no effect.
REQ-017 readdata = {13'b0, overflow, full, busy} when dataadr==STAT_ADDR, else 16'h0000; busy = (state!=IDLE) or FIFO not empty.
REQ-018 FSM states IDLE, START, DATA, STOP; shared baud counter 0..CLKS_PER_BIT-1 and 3-bit bit index.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop head into shift register, tx<=0, go START.
REQ-020 START: hold tx=0 CLKS_PER_BIT cycles, then tx<=bit0, go DATA.
REQ-021 DATA: each bit held CLKS_PER_BIT cycles, LSB first; after bit7, tx<=1, go STOP.
REQ-022 STOP: hold tx=1 CLKS_PER_BIT cycles; then if FIFO non-empty pop and go START (no idle gap), else go IDLE.
REQ-023 Frame = 10*CLKS_PER_BIT cycles; start-bit first cycle begins edge after the push edge (1-cycle latency from empty/IDLE).
REQ-024 Simultaneous push and pop on an empty FIFO: pop sees empty; byte is sent from next opportunity.
REQ-025 FIFO pointers wrap modulo DEPTH; count saturates 0..DEPTH, never under/overflows.

Reset
REQ-026 reset=0 at a rising edge: state IDLE, tx=1, FIFO emptied, counters 0, overflow 0, regardless of prior state.
REQ-027 Reset mid-frame aborts the frame; tx is 1 from that edge on; no partial byte resumes after release.
REQ-028 readdata reads 16'h0000 for one cycle after reset release with dataadr==STAT_ADDR.

Structure
REQ-029 Package mmio_pkg holds the FSM state enum, TX_ADDR/STAT_ADDR defaults, status bit positions.
REQ-030 FIFO is sub-module sync_fifo (DEPTH x 8, push/pop/full/empty, same clk/reset); serializer FSM stays in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-031 Store 16'h1255 to FFF0 -> tx low 4 cycles from next edge, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4, busy 0 after cycle 41.
REQ-032 Stores 8'hA1,A2 on consecutive cycles -> two frames back-to-back, 80 cycles, no idle gap between stop and start.
REQ-033 Six stores on consecutive cycles from empty -> 5 accepted (one popped), sixth dropped, overflow=1, readdata=16'h0007.
REQ-034 Store 16'h0001 to FFF2 with overflow=1 -> overflow=0 next cycle; store 16'h0000 to FFF2 -> unchanged.
REQ-035 reset=0 at cycle 15 of a frame with 2 bytes queued -> tx=1 next cycle, readdata=0 at STAT_ADDR, no further frames.
REQ-036 Store to 16'h0010 -> tx stays 1, busy stays 0, overflow unchanged.
